// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice reused across WIDTH
// cycles, LSB first, behind a start/ready/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  // Full-adder slice built from two half adders and an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, sum_bit, carry_next;

  always_comb begin
    ha1_s      = a_sh_q[0] ^ b_sh_q[0];
    ha1_c      = a_sh_q[0] & b_sh_q[0];
    ha2_s      = ha1_s ^ carry_q;
    ha2_c      = ha1_s & carry_q;
    sum_bit    = ha2_s;
    carry_next = ha1_c | ha2_c;
  end

  always_comb begin
    // NOTE: every next-state variable gets a hold default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          // Subtract is a + ~b + 1: the +1 enters through the carry FF.
          b_sh_d  = op ? ~b : b;
          carry_d = op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = {sum_bit, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = carry_next;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB slice.
          carry_out_d = carry_next;
          overflow_d  = carry_q ^ carry_next;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the comb block above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with an expected-result
// queue filled at acceptance and drained at each done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a, b;
  logic         ready, busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: WIDTH+1-bit sum and sign-rule overflow.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] yy;
    logic [W:0]   s;
    exp_t         e;
    yy   = o ? ~y : y;
    s    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o};
    e.r  = s[W-1:0];
    e.co = s[W];
    e.ov = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    return e;
  endfunction

  // Drive one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit hold);
    start = 1'b1; op = o; a = x; b = y;
    check("ready_before_start", ready, 1'b1);
    @(posedge clk);
    sb.push_back(model(o, x, y));
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // lat counts edges after acceptance up to the one that raises done.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat <= 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    check("done_within_bound", done, 1'b1);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_result"}, result, e.r);
    check({tag, "_carry"}, carry_out, e.co);
    check({tag, "_ovf"}, overflow, e.ov);
    check({tag, "_onehot"}, {ready, busy, done}, 3'b001);
  endtask

  task automatic full_op(input string tag, input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    int lat, nb;
    issue(o, x, y, 1'b0);
    wait_done(lat, nb);
    check({tag, "_latency"}, lat, W + 1);
    check({tag, "_busy_cycles"}, nb, W);
    check_result(tag);
    @(negedge clk);
    check({tag, "_single_done"}, {ready, busy, done}, 3'b100);
  endtask

  initial begin
    int   lat, nb, ndone, last_done;
    exp_t held;
    logic [W-1:0] ta [4] = '{8'h11, 8'hC0, 8'h7F, 8'h05};
    logic [W-1:0] tb [4] = '{8'h22, 8'h50, 8'h80, 8'h09};
    logic         to [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", {ready, busy, done}, 3'b100);
    check("reset_result", {result, carry_out, overflow}, '0);
    rst = 1'b0;
    @(negedge clk);

    full_op("add_35_4a", 1'b0, 8'h35, 8'h4A);
    full_op("add_ff_01", 1'b0, 8'hFF, 8'h01);
    full_op("add_7f_01", 1'b0, 8'h7F, 8'h01);
    full_op("sub_80_01", 1'b1, 8'h80, 8'h01);
    full_op("sub_00_01", 1'b1, 8'h00, 8'h01);
    check("idle_hold_result", result, 8'hFF);

    // Start pulsed mid-RUN with new operands must be ignored.
    issue(1'b0, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55;
    wait_done(lat, nb);
    check_result("midrun_start");
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrun_extra_done", ndone, 0);

    // Async reset during RUN cycle 4 abandons the operation.
    issue(1'b0, 8'hAA, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_flags", {ready, busy, done}, 3'b100);
    check("midreset_result", {result, carry_out, overflow}, '0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midreset_no_done", ndone, 0);
    full_op("add_10_20", 1'b0, 8'h10, 8'h20);

    // start held high: one acceptance per IDLE cycle, done every W+2 cycles.
    last_done = -1;
    for (int k = 0; k < 4; k++) begin
      issue(to[k], ta[k], tb[k], 1'b1);
      a = ~ta[k]; b = ~tb[k]; op = ~to[k];
      wait_done(lat, nb);
      check("held_latency", lat, W + 1);
      check_result("held");
      if (last_done >= 0) check("held_done_period", cyc - last_done, W + 2);
      last_done = cyc;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    held = model(to[3], ta[3], tb[3]);
    check("held_final_stable", result, held.r);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
